// File: rtl/wallace_pkg.sv
// Shared types and defaults for the multiply datapath final adder.
package wallace_pkg;

  localparam int unsigned WIDTH = 32;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

endpackage : wallace_pkg

// File: rtl/wallace_cpa_half.sv
// Combinational width-bit carry-propagate adder with carry in and carry out.
module wallace_cpa_half #(
  parameter int unsigned width = 32
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             cin,
  output logic [width-1:0] sum,
  output logic             cout
);

  // Widen by one bit so the carry out falls into the MSB.
  always_comb begin
    {cout, sum} = (width+1)'(a) + (width+1)'(b) + (width+1)'(cin);
  end

endmodule : wallace_cpa_half

// File: rtl/wallace_final_adder.sv
// Two-stage final carry-propagate add of the Wallace tree rows with product
// half select and valid/ready handshakes on both sides.
module wallace_final_adder
  import wallace_pkg::*;
#(
  parameter int unsigned width = WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*width-1:0] row_a,
  input  logic [2*width-1:0] row_b,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [width-1:0]   result
);

  // S1 registers
  logic [width-1:0] lo_sum_q,   lo_sum_d;
  logic             lo_carry_q, lo_carry_d;
  logic [width-1:0] hi_a_q,     hi_a_d;
  logic [width-1:0] hi_b_q,     hi_b_d;
  mul_op_t          op_q,       op_d;
  logic             s1_valid_q, s1_valid_d;

  // S2 registers
  logic [width-1:0] result_q,   result_d;
  logic             s2_valid_q, s2_valid_d;

  logic [width-1:0] lo_sum_c;
  logic             lo_carry_c;
  logic [width-1:0] hi_sum_c;
  logic             hi_cout_unused;
  logic             s2_load;
  logic             accept;

  // Low half add straight from the incoming rows.
  wallace_cpa_half #(.width(width)) u_cpa_lo (
    .a    (row_a[width-1:0]),
    .b    (row_b[width-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum_c),
    .cout (lo_carry_c)
  );

  // High half add from the S1 registers; carry out of the full sum is dropped.
  wallace_cpa_half #(.width(width)) u_cpa_hi (
    .a    (hi_a_q),
    .b    (hi_b_q),
    .cin  (lo_carry_q),
    .sum  (hi_sum_c),
    .cout (hi_cout_unused)
  );

  // Handshake, next-state and data-path selection.
  always_comb begin
    lo_sum_d   = lo_sum_q;
    lo_carry_d = lo_carry_q;
    hi_a_d     = hi_a_q;
    hi_b_d     = hi_b_q;
    op_d       = op_q;
    s1_valid_d = s1_valid_q;
    result_d   = result_q;
    s2_valid_d = s2_valid_q;

    s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready = !flush && (!s1_valid_q || s2_load);
    accept   = in_valid && in_ready;

    // S2: load the selected half, or empty after a downstream handshake.
    if (s2_load) begin
      result_d   = (op_q == MUL) ? lo_sum_q : hi_sum_c;
      s2_valid_d = 1'b1;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end

    // S1: capture a new transaction, or empty when it moved into S2.
    if (accept) begin
      lo_sum_d   = lo_sum_c;
      lo_carry_d = lo_carry_c;
      hi_a_d     = row_a[2*width-1:width];
      hi_b_d     = row_b[2*width-1:width];
      op_d       = mul_op_t'(op);
      s1_valid_d = 1'b1;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    // Flush kills both stages; in_ready already blocked any accept.
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  // Pipeline registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_sum_q   <= '0;
      lo_carry_q <= 1'b0;
      hi_a_q     <= '0;
      hi_b_q     <= '0;
      op_q       <= MUL;
      s1_valid_q <= 1'b0;
      result_q   <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      lo_sum_q   <= lo_sum_d;
      lo_carry_q <= lo_carry_d;
      hi_a_q     <= hi_a_d;
      hi_b_q     <= hi_b_d;
      op_q       <= op_d;
      s1_valid_q <= s1_valid_d;
      result_q   <= result_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;

endmodule : wallace_final_adder

// File: tb/tb_wallace_final_adder.sv
// Directed-vector bench for the Wallace final adder.
module tb_wallace_final_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] row_a;
  logic [63:0] row_b;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULH  = 2'b01;
  localparam logic [1:0] OP_MULHU = 2'b11;

  wallace_final_adder #(.width(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .row_a     (row_a),
    .row_b     (row_b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [1:0] o);
    in_valid = 1'b1;
    row_a    = a;
    row_b    = b;
    op       = o;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    row_a = '0; row_b = '0; op = OP_MUL;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Single MUL: low half wraps to zero, latency two edges.
    out_ready = 1'b1;
    drive(64'h0000_0001_FFFF_FFFF, 64'h1, OP_MUL);
    check("mul_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("mul_lat1_valid", 64'(out_valid), 64'd0);
    tick();
    check("mul_valid", 64'(out_valid), 64'd1);
    check("mul_result", 64'(result), 64'h0);
    tick();
    check("mul_drained", 64'(out_valid), 64'd0);

    // Same rows, high half: carry from the low half propagates.
    drive(64'h0000_0001_FFFF_FFFF, 64'h1, OP_MULHU);
    tick();
    in_valid = 1'b0;
    tick();
    check("mulhu_valid", 64'(out_valid), 64'd1);
    check("mulhu_result", 64'(result), 64'h2);
    tick();

    // Wrap-around: carry out of bit 63 discarded.
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, OP_MULH);
    tick();
    in_valid = 1'b0;
    tick();
    check("wrap_result", 64'(result), 64'hFFFF_FFFF);
    tick();

    // Streaming: three back-to-back MULs.
    drive(64'd5, 64'd7, OP_MUL);
    check("str_rdy0", 64'(in_ready), 64'd1);
    tick();
    drive(64'd9, 64'd1, OP_MUL);
    check("str_rdy1", 64'(in_ready), 64'd1);
    tick();
    check("str_res0", 64'(result), 64'd12);
    drive(64'd2, 64'd2, OP_MUL);
    check("str_rdy2", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("str_res1", 64'(result), 64'd10);
    check("str_val1", 64'(out_valid), 64'd1);
    tick();
    check("str_res2", 64'(result), 64'd4);
    check("str_val2", 64'(out_valid), 64'd1);
    tick();
    check("str_empty", 64'(out_valid), 64'd0);

    // Backpressure: two accepts fill the stage.
    out_ready = 1'b0;
    drive(64'd3, 64'd4, OP_MUL);
    tick();
    drive(64'd10, 64'd20, OP_MUL);
    check("bp_rdy_second", 64'(in_ready), 64'd1);
    tick();
    drive(64'd50, 64'd50, OP_MUL);
    check("bp_rdy_full", 64'(in_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_result", 64'(result), 64'd7);
      check("bp_hold_rdy", 64'(in_ready), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp_rdy_release", 64'(in_ready), 64'd1);
    check("bp_drain0", 64'(result), 64'd7);
    tick();
    check("bp_drain1_valid", 64'(out_valid), 64'd1);
    check("bp_drain1", 64'(result), 64'd30);
    tick();
    check("bp_empty", 64'(out_valid), 64'd0);

    // Flush with two transactions in flight.
    out_ready = 1'b0;
    drive(64'd1, 64'd1, OP_MUL);
    tick();
    drive(64'd2, 64'd3, OP_MUL);
    tick();
    check("fl_full_valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    drive(64'd40, 64'd2, OP_MUL);
    #1;
    check("fl_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_valid0", 64'(out_valid), 64'd0);
    tick();
    check("fl_valid1", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    tick();
    check("fl_valid2", 64'(out_valid), 64'd0);
    drive(64'd100, 64'd23, OP_MUL);
    tick();
    in_valid = 1'b0;
    tick();
    check("fl_post_valid", 64'(out_valid), 64'd1);
    check("fl_post_result", 64'(result), 64'd123);
    tick();

    // Asynchronous reset while a result is held.
    out_ready = 1'b0;
    drive(64'h0000_0005_0000_0000, 64'h0, OP_MULHU);
    tick();
    in_valid = 1'b0;
    tick();
    check("ar_pre_result", 64'(result), 64'd5);
    #1;
    rst = 1'b1;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_result", 64'(result), 64'd0);
    #1;
    rst = 1'b0;
    #1;
    check("ar_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    check("ar_stale0", 64'(out_valid), 64'd0);
    tick();
    check("ar_stale1", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_wallace_final_adder
